hdmi_video_sequencer: RTL and testbench



---
 rtl/hdmi_video_sequencer.sv | 139 +++++++++++++
 tb/tb_hdmi_video_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_sequencer.sv
// Pixel-clock timing controller and pixel scheduler for the TMDS/DVI path.
// Counts the raster, pulls pixels on active slots and registers rgb/sync/de together.
module hdmi_video_sequencer #(
    parameter int          H_SYNC        = 96,
    parameter int          H_BP          = 48,
    parameter int          H_ACTIVE      = 640,
    parameter int          H_FP          = 16,
    parameter int          V_SYNC        = 2,
    parameter int          V_BP          = 33,
    parameter int          V_ACTIVE      = 480,
    parameter int          V_FP          = 10,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
    input  logic        clk25,
    input  logic        resetn,
    input  logic        enable,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [23:0] rgb_out,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        busy,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic [10:0] hcount,
    output logic [10:0] vcount
);

    localparam logic [10:0] H_LAST   = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [10:0] V_LAST   = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_W = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_LO = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_HI = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [10:0] V_ACT_LO = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT_HI = 11'(V_SYNC + V_BP + V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        running;
    logic        line_end;
    logic        frame_end;
    logic        h_act;
    logic        v_act;
    logic        active;

    assign running   = (state != IDLE);
    assign line_end  = (hc == H_LAST);
    assign frame_end = line_end && (vc == V_LAST);
    assign h_act     = (hc >= H_ACT_LO) && (hc <= H_ACT_HI);
    assign v_act     = (vc >= V_ACT_LO) && (vc <= V_ACT_HI);
    assign active    = h_act && v_act;
    assign pix_ready = running && active;
    assign busy      = running;
    assign hcount    = hc;
    assign vcount    = vc;

    always_ff @(posedge clk25) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A stop request only takes effect at the end of a frame, so the
    // sink never sees a truncated frame.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (!enable) state_next = STOPPING;
            end
            STOPPING: begin
                if (enable) begin
                    state_next = RUN;
                end else if (frame_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (!resetn || !running) begin
            hc <= '0;
            vc <= '0;
        end else if (line_end) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 11'd0 : vc + 11'd1;
        end else begin
            hc <= hc + 11'd1;
        end
    end

    // Every output is registered from the same counter state so that
    // rgb, de and both syncs stay aligned for the encoders.
    always_ff @(posedge clk25) begin
        if (!resetn) begin
            rgb_out     <= '0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            de          <= pix_ready;
            hsync       <= running && (hc < H_SYNC_W);
            vsync       <= running && (vc < V_SYNC_W);
            frame_start <= running && (hc == 11'd0) && (vc == 11'd0);
            if (pix_ready) begin
                rgb_out <= pix_valid ? pix_data : UNDERFLOW_RGB;
            end else begin
                rgb_out <= '0;
            end
            if (pix_ready && !pix_valid) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_video_sequencer.sv
// Bench for hdmi_video_sequencer on a reduced raster (17 x 10, frame 170 cycles).
// Pixel data is scoreboarded; timing is checked against hand-computed counts.
module tb_hdmi_video_sequencer;

    localparam int FRAME = 170;

    logic        clk25;
    logic        resetn;
    logic        enable;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] rgb_out;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic        busy;
    logic        underflow;
    logic        underflow_clr;
    logic [10:0] hcount;
    logic [10:0] vcount;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_on = 0;
    logic [23:0] q[$];

    hdmi_video_sequencer #(
        .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(2),
        .UNDERFLOW_RGB(24'hFF00FF)
    ) dut (
        .clk25(clk25),
        .resetn(resetn),
        .enable(enable),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .rgb_out(rgb_out),
        .de(de),
        .hsync(hsync),
        .vsync(vsync),
        .frame_start(frame_start),
        .busy(busy),
        .underflow(underflow),
        .underflow_clr(underflow_clr),
        .hcount(hcount),
        .vcount(vcount)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    always @(posedge clk25) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected pixel for each de cycle, then records
    // what the source offered in the current cycle if it was consumed.
    always @(negedge clk25) begin
        if (mon_on) begin
            if (de) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty actual=de_without_pixel t=%0t", $time);
                end else begin
                    check("rgb_active", 32'(rgb_out), 32'(q.pop_front()));
                end
            end else begin
                check("rgb_blank", 32'(rgb_out), 32'd0);
            end
            if (resetn && pix_ready) begin
                q.push_back(pix_valid ? pix_data : 24'hFF00FF);
            end
        end
    end

    initial begin
        pix_data = 24'h000000;
        forever begin
            @(posedge clk25);
            #1;
            pix_data = pix_data + 24'h010203;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_pos(input int h, input int v);
        bit found = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk25);
            #1;
            if (hcount == 11'(h) && vcount == 11'(v)) begin
                found = 1;
                break;
            end
        end
        check("pos_reached", 32'(found), 32'd1);
    endtask

    task automatic wait_fs();
        bit found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk25);
            if (frame_start) begin
                found = 1;
                break;
            end
        end
        check("fs_seen", 32'(found), 32'd1);
    endtask

    // Called at a negedge showing frame_start; returns at the next one.
    task automatic frame_stats(input string tag);
        int period = 0;
        int de_n = 0;
        int hs_n = 0;
        int vs_n = 0;
        int first_de = -1;
        int run = 0;
        int max_run = 0;
        for (int i = 0; i < 400; i++) begin
            if (i > 0 && frame_start) begin
                period = i;
                break;
            end
            if (de) begin
                de_n++;
                run++;
                if (run > max_run) max_run = run;
                if (first_de < 0) first_de = i;
            end else begin
                run = 0;
            end
            if (hsync) hs_n++;
            if (vsync) vs_n++;
            @(negedge clk25);
        end
        check({tag, "_period"}, 32'(period), 32'(FRAME));
        check({tag, "_de_cycles"}, 32'(de_n), 32'd32);
        check({tag, "_hs_cycles"}, 32'(hs_n), 32'd40);
        check({tag, "_vs_cycles"}, 32'(vs_n), 32'd34);
        check({tag, "_first_de"}, 32'(first_de), 32'd75);
        check({tag, "_de_run"}, 32'(max_run), 32'd8);
    endtask

    initial begin
        int n;
        int de_n;
        int t0;
        int t1;
        resetn = 1'b0;
        enable = 1'b0;
        pix_valid = 1'b1;
        underflow_clr = 1'b0;
        repeat (3) @(posedge clk25);
        @(negedge clk25);
        check("rst_rgb", 32'(rgb_out), 32'd0);
        check("rst_de", 32'(de), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd0);
        check("rst_vsync", 32'(vsync), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_uf", 32'(underflow), 32'd0);
        check("rst_hc", 32'(hcount), 32'd0);
        check("rst_vc", 32'(vcount), 32'd0);
        check("rst_ready", 32'(pix_ready), 32'd0);
        mon_on = 1;

        @(posedge clk25);
        #1 resetn = 1'b1;
        repeat (3) @(posedge clk25);
        @(negedge clk25);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_hc", 32'(hcount), 32'd0);
        check("idle_ready", 32'(pix_ready), 32'd0);

        @(posedge clk25);
        #1 enable = 1'b1;
        @(negedge clk25);
        check("pre_run_busy", 32'(busy), 32'd0);
        @(negedge clk25);
        check("run_busy", 32'(busy), 32'd1);
        check("run_hc0", 32'(hcount), 32'd0);
        check("run_fs_early", 32'(frame_start), 32'd0);
        @(negedge clk25);
        check("first_fs", 32'(frame_start), 32'd1);
        check("first_hsync", 32'(hsync), 32'd1);
        check("first_vsync", 32'(vsync), 32'd1);
        check("first_de", 32'(de), 32'd0);
        check("first_hc", 32'(hcount), 32'd1);
        frame_stats("f1");

        check("uf_initial", 32'(underflow), 32'd0);
        wait_pos(9, 5);
        pix_valid = 1'b0;
        repeat (2) begin
            @(posedge clk25);
            #1;
        end
        pix_valid = 1'b1;
        @(negedge clk25);
        check("uf_set", 32'(underflow), 32'd1);

        wait_pos(8, 6);
        pix_valid = 1'b0;
        underflow_clr = 1'b1;
        @(posedge clk25);
        #1;
        pix_valid = 1'b1;
        underflow_clr = 1'b0;
        @(negedge clk25);
        check("uf_set_wins", 32'(underflow), 32'd1);

        wait_pos(2, 7);
        underflow_clr = 1'b1;
        @(posedge clk25);
        #1 underflow_clr = 1'b0;
        @(negedge clk25);
        check("uf_cleared", 32'(underflow), 32'd0);

        wait_fs();
        frame_stats("f3");

        wait_pos(0, 2);
        enable = 1'b0;
        n = 0;
        de_n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk25);
            n++;
            if (de) de_n++;
            if (!busy) break;
        end
        check("stop_cycles", 32'(n), 32'd137);
        check("stop_de_cycles", 32'(de_n), 32'd32);
        check("stop_de", 32'(de), 32'd0);
        check("stop_hsync", 32'(hsync), 32'd0);
        check("stop_vsync", 32'(vsync), 32'd0);
        check("stop_hc", 32'(hcount), 32'd0);
        check("stop_vc", 32'(vcount), 32'd0);
        repeat (5) @(negedge clk25);
        check("stopped_hc", 32'(hcount), 32'd0);
        check("stopped_busy", 32'(busy), 32'd0);
        check("stopped_de", 32'(de), 32'd0);
        check("stopped_hsync", 32'(hsync), 32'd0);

        @(posedge clk25);
        #1 enable = 1'b1;
        wait_fs();
        t0 = cyc;
        wait_pos(0, 2);
        enable = 1'b0;
        wait_pos(0, 3);
        enable = 1'b1;
        wait_fs();
        t1 = cyc;
        check("resume_period", 32'(t1 - t0), 32'(FRAME));

        wait_pos(9, 5);
        pix_valid = 1'b0;
        @(posedge clk25);
        #1;
        pix_valid = 1'b1;
        resetn = 1'b0;
        @(negedge clk25);
        check("pre_rst_uf", 32'(underflow), 32'd1);
        check("pre_rst_de", 32'(de), 32'd1);
        @(posedge clk25);
        #1 resetn = 1'b1;
        @(negedge clk25);
        check("mid_rst_rgb", 32'(rgb_out), 32'd0);
        check("mid_rst_de", 32'(de), 32'd0);
        check("mid_rst_hsync", 32'(hsync), 32'd0);
        check("mid_rst_vsync", 32'(vsync), 32'd0);
        check("mid_rst_fs", 32'(frame_start), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_uf", 32'(underflow), 32'd0);
        check("mid_rst_hc", 32'(hcount), 32'd0);
        check("mid_rst_vc", 32'(vcount), 32'd0);
        @(negedge clk25);
        check("restart_busy", 32'(busy), 32'd1);
        @(negedge clk25);
        check("restart_fs", 32'(frame_start), 32'd1);
        check("sb_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
